// File: rtl/any1_pkg.sv
// Shared types for the ANY-1 load/store path: vector address-generation modes
// and the latched control fields of a vector memory request.
package any1_pkg;

  typedef enum logic [1:0] {
    AGEN_UNIT   = 2'd0,
    AGEN_STRIDE = 2'd1,
    AGEN_INDEX  = 2'd2,
    AGEN_RSVD   = 2'd3
  } agen_mode_t;

  // Width-independent req_* fields; base/imm/stride/mask stay parametric in the top.
  typedef struct packed {
    agen_mode_t mode;
    logic [1:0] sz;
    logic [2:0] sc;
  } vagen_req_t;

endpackage

// File: rtl/any1_vagen_lane.sv
// Combinational effective address of one lane from the group pointer.
// Zero latency, no flow control.
module any1_vagen_lane
  import any1_pkg::*;
#(
  parameter int AWID = 32
) (
  input  agen_mode_t      mode_i,
  input  logic [AWID-1:0] ptr_i,
  input  logic [1:0]      lane_i,
  input  logic [AWID-1:0] stride_i,
  input  logic [1:0]      sz_i,
  input  logic [2:0]      sc_i,
  input  logic [AWID-1:0] idx_i,
  output logic [AWID-1:0] addr_o
);

  logic [AWID-1:0] lane_w;
  logic [AWID-1:0] lane_stride;

  // lane*stride for lane 0..3 built from shifts and one add.
  always_comb begin
    lane_w = AWID'(lane_i);
    case (lane_i)
      2'd0:    lane_stride = '0;
      2'd1:    lane_stride = stride_i;
      2'd2:    lane_stride = stride_i << 1;
      default: lane_stride = (stride_i << 1) + stride_i;
    endcase
  end

  always_comb begin
    addr_o = ptr_i;
    case (mode_i)
      AGEN_UNIT:   addr_o = ptr_i + (lane_w << sz_i);
      AGEN_STRIDE: addr_o = ptr_i + lane_stride;
      AGEN_INDEX:  addr_o = ptr_i + (idx_i << sc_i);
      default:     addr_o = ptr_i;
    endcase
  end

endmodule

// File: rtl/any1_vagen.sv
// Vector address sequencer: one request in, LANES-wide address beats out; first beat at T+1 (INDEX: after idx handshake).
// Registered outputs hold while ea_ready is low; index groups are pulled only when the output register is free.
module any1_vagen
  import any1_pkg::*;
#(
  parameter int AWID  = 32,
  parameter int LANES = 2,
  parameter int MAXVL = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_mode,
  input  logic [AWID-1:0]           req_base,
  input  logic [AWID-1:0]           req_imm,
  input  logic [AWID-1:0]           req_stride,
  input  logic [1:0]                req_sz,
  input  logic [2:0]                req_sc,
  input  logic [$clog2(MAXVL):0]    req_vl,
  input  logic [MAXVL-1:0]          req_mask,
  input  logic                      idx_valid,
  output logic                      idx_ready,
  input  logic [LANES*AWID-1:0]     idx_val,
  output logic                      ea_valid,
  input  logic                      ea_ready,
  output logic [LANES*AWID-1:0]     ea,
  output logic [LANES-1:0]          ea_lmask,
  output logic [$clog2(MAXVL)-1:0]  ea_elem,
  output logic                      ea_last,
  output logic                      done,
  output logic                      err
);

  localparam int VLW = $clog2(MAXVL) + 1;
  localparam int EW  = $clog2(MAXVL);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 state_q, state_d;
  vagen_req_t             cfg_q, cfg_d;
  logic [AWID-1:0]        ptr_q, ptr_d;
  logic [AWID-1:0]        stride_q, stride_d;
  logic [AWID-1:0]        inc_q, inc_d;
  logic [MAXVL-1:0]       act_q, act_d;
  logic [VLW-1:0]         e_q, e_d;
  logic                   ea_valid_q, ea_valid_d;
  logic [LANES*AWID-1:0]  ea_q, ea_d;
  logic [LANES-1:0]       lmask_q, lmask_d;
  logic [EW-1:0]          elem_q, elem_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [MAXVL-1:0]       req_act;
  logic [MAXVL-1:0]       act_rest;
  logic [LANES-1:0]       grp_mask;
  logic [LANES*AWID-1:0]  lane_addr;
  logic [LANES*AWID-1:0]  grp_ea;
  logic                   out_free, idx_ok, gen, step, finish;

  always_comb begin
    req_act = '0;
    for (int i = 0; i < MAXVL; i++) begin
      req_act[i] = req_mask[i] && (VLW'(i) < req_vl);
    end
  end

  // act_q is the remaining active-element map, shifted down one group per step,
  // so its low LANES bits are the current group and the rest is the ea_last lookahead.
  assign grp_mask = act_q[LANES-1:0];
  assign act_rest = act_q >> LANES;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    any1_vagen_lane #(.AWID(AWID)) u_lane (
      .mode_i   (cfg_q.mode),
      .ptr_i    (ptr_q),
      .lane_i   (2'(l)),
      .stride_i (stride_q),
      .sz_i     (cfg_q.sz),
      .sc_i     (cfg_q.sc),
      .idx_i    (idx_val[l*AWID +: AWID]),
      .addr_o   (lane_addr[l*AWID +: AWID])
    );
  end

  always_comb begin
    grp_ea = '0;
    for (int l = 0; l < LANES; l++) begin
      if (grp_mask[l]) grp_ea[l*AWID +: AWID] = lane_addr[l*AWID +: AWID];
    end
  end

  assign out_free  = !ea_valid_q || ea_ready;
  assign idx_ok    = (cfg_q.mode != AGEN_INDEX) || idx_valid;
  assign gen       = (state_q == S_RUN) && (act_q != '0);
  assign step      = gen && out_free && idx_ok;
  assign finish    = (state_q == S_RUN) && (act_q == '0) && out_free;
  assign idx_ready = gen && out_free && (cfg_q.mode == AGEN_INDEX);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    ptr_d      = ptr_q;
    stride_d   = stride_q;
    inc_d      = inc_q;
    act_d      = act_q;
    e_d        = e_q;
    ea_valid_d = ea_valid_q;
    ea_d       = ea_q;
    lmask_d    = lmask_q;
    elem_d     = elem_q;
    last_d     = last_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_RUN;
          cfg_d    = '{mode: agen_mode_t'(req_mode), sz: req_sz, sc: req_sc};
          ptr_d    = req_base + req_imm;
          stride_d = req_stride;
          e_d      = '0;
          act_d    = (agen_mode_t'(req_mode) == AGEN_RSVD) ? '0 : req_act;
          case (agen_mode_t'(req_mode))
            AGEN_UNIT:   inc_d = AWID'(LANES) << req_sz;
            AGEN_STRIDE: inc_d = AWID'(LANES) * req_stride;
            default:     inc_d = '0;
          endcase
        end
      end
      S_RUN: begin
        if (ea_valid_q && ea_ready) ea_valid_d = 1'b0;
        // Empty groups still advance pointer/element and consume their index group.
        if (step) begin
          act_d = act_rest;
          e_d   = e_q + VLW'(LANES);
          ptr_d = ptr_q + inc_q;
          if (grp_mask != '0) begin
            ea_valid_d = 1'b1;
            ea_d       = grp_ea;
            lmask_d    = grp_mask;
            elem_d     = e_q[EW-1:0];
            last_d     = (act_rest == '0);
          end
        end
        if (finish) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = (cfg_q.mode == AGEN_RSVD);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cfg_q      <= '{mode: AGEN_UNIT, sz: 2'd0, sc: 3'd0};
      ptr_q      <= '0;
      stride_q   <= '0;
      inc_q      <= '0;
      act_q      <= '0;
      e_q        <= '0;
      ea_valid_q <= 1'b0;
      ea_q       <= '0;
      lmask_q    <= '0;
      elem_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      ptr_q      <= ptr_d;
      stride_q   <= stride_d;
      inc_q      <= inc_d;
      act_q      <= act_d;
      e_q        <= e_d;
      ea_valid_q <= ea_valid_d;
      ea_q       <= ea_d;
      lmask_q    <= lmask_d;
      elem_q     <= elem_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign ea_valid  = ea_valid_q;
  assign ea        = ea_q;
  assign ea_lmask  = lmask_q;
  assign ea_elem   = elem_q;
  assign ea_last   = last_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_any1_vagen.sv
// Directed bench for any1_vagen: expected beats are queued when a request is driven
// and popped by a monitor on every address handshake.
module tb_any1_vagen;

  localparam int AWID  = 32;
  localparam int LANES = 2;
  localparam int MAXVL = 64;

  logic                     clk;
  logic                     rst_n;
  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_mode;
  logic [AWID-1:0]          req_base, req_imm, req_stride;
  logic [1:0]               req_sz;
  logic [2:0]               req_sc;
  logic [6:0]               req_vl;
  logic [MAXVL-1:0]         req_mask;
  logic                     idx_valid;
  logic                     idx_ready;
  logic [LANES*AWID-1:0]    idx_val;
  logic                     ea_valid;
  logic                     ea_ready;
  logic [LANES*AWID-1:0]    ea;
  logic [LANES-1:0]         ea_lmask;
  logic [5:0]               ea_elem;
  logic                     ea_last;
  logic                     done;
  logic                     err;

  any1_vagen #(.AWID(AWID), .LANES(LANES), .MAXVL(MAXVL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_base   (req_base),
    .req_imm    (req_imm),
    .req_stride (req_stride),
    .req_sz     (req_sz),
    .req_sc     (req_sc),
    .req_vl     (req_vl),
    .req_mask   (req_mask),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .idx_val    (idx_val),
    .ea_valid   (ea_valid),
    .ea_ready   (ea_ready),
    .ea         (ea),
    .ea_lmask   (ea_lmask),
    .ea_elem    (ea_elem),
    .ea_last    (ea_last),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [LANES*AWID-1:0] ea;
    logic [LANES-1:0]      lm;
    logic [5:0]            elem;
    logic                  last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] idx_tab [0:MAXVL-1];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          t_acc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lane_bits(input logic [1:0] lm);
    return {{32{lm[1]}}, {32{lm[0]}}};
  endfunction

  // Reference: each lane address computed from its element number directly.
  task automatic model(input int mode, input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] stride, input int sz, input int sc,
                       input int vl, input logic [63:0] mask);
    beat_t tmp[$];
    beat_t b;
    logic [31:0] a;
    if (mode == 3) return;
    for (int e = 0; e < MAXVL; e += LANES) begin
      b = '0;
      for (int l = 0; l < LANES; l++) begin
        int el;
        el = e + l;
        if (el < vl && el < MAXVL && mask[el]) begin
          b.lm[l] = 1'b1;
          if (mode == 0)      a = base + imm + (32'(el) << sz);
          else if (mode == 1) a = base + imm + 32'(el) * stride;
          else                a = base + imm + (idx_tab[el] << sc);
          b.ea[l*AWID +: AWID] = a;
        end
      end
      if (b.lm != '0) begin
        b.elem = 6'(e);
        tmp.push_back(b);
      end
    end
    if (tmp.size() > 0) tmp[tmp.size()-1].last = 1'b1;
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
  endtask

  always @(negedge clk) begin : mon
    beat_t b;
    if (rst_n && ea_valid && ea_ready) begin
      chk("sb_beat_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("ea_lmask", 64'(ea_lmask), 64'(b.lm));
        chk("ea_elem",  64'(ea_elem),  64'(b.elem));
        chk("ea_last",  64'(ea_last),  64'(b.last));
        chk("ea_addr",  64'(ea) & lane_bits(b.lm), 64'(b.ea));
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the acceptance edge.
  task automatic send_req(input logic [1:0] mode, input logic [31:0] base, input logic [31:0] imm,
                          input logic [31:0] stride, input logic [1:0] sz, input logic [2:0] sc,
                          input logic [6:0] vl, input logic [63:0] mask);
    req_mode = mode; req_base = base; req_imm = imm; req_stride = stride;
    req_sz = sz; req_sc = sc; req_vl = vl; req_mask = mask;
    req_valid = 1'b1;
    model(int'(mode), base, imm, stride, int'(sz), int'(sc), int'(vl), mask);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input string tag, input int lat, input logic exp_err);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_done_lat"}, 64'(cyc - t_acc), 64'(lat));
      chk({tag, "_err"}, 64'(err), 64'(exp_err));
      chk({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    end
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    logic [63:0] snap_ea;
    logic [5:0]  snap_el;
    logic [1:0]  snap_lm;
    logic        snap_last;
    bit          stable;

    rst_n = 1'b0; req_valid = 1'b0; req_mode = 2'd0; req_base = '0; req_imm = '0;
    req_stride = '0; req_sz = '0; req_sc = '0; req_vl = '0; req_mask = '0;
    idx_valid = 1'b0; idx_val = '0; ea_ready = 1'b1;
    for (int i = 0; i < MAXVL; i++) idx_tab[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_ea_valid",  64'(ea_valid),  64'd0);
    chk("rst_idx_ready", 64'(idx_ready), 64'd0);
    chk("rst_flags",     64'({ea_last, done, err}), 64'd0);
    chk("rst_ea",        64'(ea), 64'd0);
    chk("rst_lmask_elem", 64'({ea_lmask, ea_elem}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unit stride with a partial final group.
    send_req(2'd0, 32'h1000, 32'h10, 32'h0, 2'd2, 3'd0, 7'd5, {64{1'b1}});
    chk("unit_no_valid_T", 64'(ea_valid), 64'd0);
    @(posedge clk); #1;
    chk("unit_valid_T1", 64'(ea_valid), 64'd1);
    wait_done("unit", 4, 1'b0);

    // Two empty groups in the middle, one cycle each.
    send_req(2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 7'd8, 64'hC3);
    wait_done("skip", 5, 1'b0);

    // Indexed with a late index stream.
    idx_tab[0] = 32'd1; idx_tab[1] = 32'd2; idx_tab[2] = 32'd5; idx_tab[3] = 32'd0;
    send_req(2'd2, 32'h8000, 32'h0, 32'h0, 2'd0, 3'd3, 7'd4, {64{1'b1}});
    repeat (3) begin
      chk("idx_wait_no_valid", 64'(ea_valid), 64'd0);
      @(posedge clk); #1;
    end
    idx_val = {32'd2, 32'd1};
    idx_valid = 1'b1;
    @(negedge clk);
    chk("idx_ready_g0", 64'(idx_ready), 64'd1);
    chk("idx_pre_hs_no_valid", 64'(ea_valid), 64'd0);
    @(posedge clk); #1;
    chk("idx_valid_after_hs", 64'(ea_valid), 64'd1);
    idx_val = {32'd0, 32'd5};
    @(negedge clk);
    chk("idx_ready_g1", 64'(idx_ready), 64'd1);
    @(posedge clk); #1;
    idx_valid = 1'b0;
    wait_done("index", 6, 1'b0);

    // Zero-length request.
    send_req(2'd0, 32'h40, 32'h0, 32'h0, 2'd0, 3'd0, 7'd0, {64{1'b1}});
    wait_done("vl0", 1, 1'b0);

    // Reserved mode.
    send_req(2'd3, 32'h40, 32'h0, 32'h4, 2'd0, 3'd0, 7'd4, {64{1'b1}});
    wait_done("rsvd", 1, 1'b1);

    // Consumer stall for four cycles on the second beat.
    send_req(2'd0, 32'h0, 32'h0, 32'h0, 2'd3, 3'd0, 7'd8, {64{1'b1}});
    @(posedge clk); #1;
    @(posedge clk); #1;
    ea_ready = 1'b0;
    snap_ea = 64'(ea); snap_el = ea_elem; snap_lm = ea_lmask; snap_last = ea_last;
    stable = ea_valid;
    repeat (4) begin
      @(posedge clk); #1;
      if (!ea_valid || 64'(ea) !== snap_ea || ea_elem !== snap_el ||
          ea_lmask !== snap_lm || ea_last !== snap_last) stable = 1'b0;
    end
    chk("stall_hold", 64'(stable), 64'd1);
    chk("stall_elem", 64'(snap_el), 64'd2);
    ea_ready = 1'b1;
    wait_done("stall", 9, 1'b0);

    // Reset in the middle of a request.
    send_req(2'd0, 32'h100, 32'h0, 32'h0, 2'd2, 3'd0, 7'd8, {64{1'b1}});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    ea_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_ea_valid",  64'(ea_valid),  64'd0);
    chk("abort_done",      64'(done),      64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    ea_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
    end
    @(posedge clk); #1;

    // Strided with a negative stride wrapping through zero.
    send_req(2'd1, 32'h20, 32'h0, 32'hFFFF_FFF0, 2'd0, 3'd0, 7'd4, {64{1'b1}});
    wait_done("stride", 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/any1_vagen.md
# any1_vagen

Multi-lane vector address sequencer for the ANY-1 load/store path. It accepts one vector memory request and emits a stream of effective-address groups, up to LANES addresses per beat, in unit-stride, strided or indexed mode. Masked-off elements are suppressed, and groups with no active lane are skipped entirely. It sits between the issue stage and the memory queue, replacing the single-cycle scalar address path for vector loads and stores.

## Interface
- AWID, 32, address/value width
- LANES, 2, addresses per output beat (1..4)
- MAXVL, 64, maximum vector length (power of 2)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  block idle, will accept
- req_mode  in  2  0 UNIT, 1 STRIDE, 2 INDEX, 3 reserved
- req_base, req_imm, req_stride  in  AWID each  base register, displacement, byte stride
- req_sz  in  2  element size 1<<sz bytes (UNIT)
- req_sc  in  3  index shift (INDEX)
- req_vl  in  $clog2(MAXVL)+1  vector length
- req_mask  in  MAXVL  element enable mask
- idx_valid  in  1  index group offered
- idx_ready  out  1  index group consumed
- idx_val  in  LANES*AWID  one index per lane
- ea_valid  out  1  address group valid
- ea_ready  in  1  consumer accepts
- ea  out  LANES*AWID  lane addresses
- ea_lmask  out  LANES  active lanes in beat
- ea_elem  out  $clog2(MAXVL)  element number of lane 0
- ea_last  out  1  final beat of request
- done  out  1  one-cycle pulse, request complete
- err  out  1  one-cycle pulse, reserved mode

## Operation
- FSM: IDLE -> RUN on req_valid&&req_ready; RUN -> IDLE when the final beat handshakes, or immediately when there is nothing to emit.
- req_ready = (state==IDLE). The request is latched on acceptance.
- Element i is active iff i<vl && mask[i]. A group covers elements e..e+LANES-1, with e stepping by LANES.
- Lane l address: UNIT: base+imm+((e+l)<<sz). STRIDE: base+imm+(e+l)*stride. INDEX: base+imm+(idx_val[l]<<sc).
- All arithmetic is modulo 2^AWID; wrap is silent.
- STRIDE uses a running pointer, incremented by LANES*stride per group. No full multiplier.
- Group with zero active lanes: no beat is emitted and the pointer still advances. In INDEX mode its index group is still consumed, which keeps the index stream aligned.
- INDEX: a group waits for idx_valid. idx_ready pulses on the cycle the group is loaded into the output register.
- ea_last is set on the beat after which no active element remains.
- done pulses in the cycle after the final handshake.
- vl==0 or all lanes inactive: no beats; done pulses the cycle after acceptance.
- Mode 3: request accepted, no beats; err and done pulse together the cycle after acceptance.

## Timing
- Reset: state IDLE; req_ready=1; ea_valid, idx_ready, ea_last, done, err = 0; ea, ea_lmask, ea_elem = 0.
- UNIT/STRIDE: first ea_valid at T+1 after the acceptance edge T. INDEX: first ea_valid the cycle after the idx handshake.
- Throughput: one beat per cycle while ea_ready=1. Skipped groups cost one cycle each.
- Outputs are registered. While ea_valid && !ea_ready, ea/ea_lmask/ea_elem/ea_last hold stable.
- One bubble between requests: req_ready rises the cycle after the final beat handshake.
- rst_n low mid-request aborts the request. All outputs take reset values at the next edge; no done pulse.

## Structure
- any1_pkg gains: agen_mode_t enum (AGEN_UNIT, AGEN_STRIDE, AGEN_INDEX, AGEN_RSVD) and a vagen_req_t struct bundling the req_* fields.
- Sub-module any1_vagen_lane: combinational per-lane address compute, generated LANES times. Its inputs are the mode, running pointer, lane number, stride, sz, sc and idx.
- The top level holds the FSM, element counter, mask lookahead for ea_last, and the output register.

## Test plan
- UNIT, base 0x1000, imm 0x10, sz=2, vl=5, mask all-ones -> beats {0x1010,0x1014}, {0x1018,0x101C}, {0x1020,x} with lmask 01 and ea_last; ea_elem 0,2,4; done follows.
- STRIDE, base 0x20, stride 0xFFFFFFF0, vl=4 -> {0x20,0x10}, {0x0,0xFFFFFFF0} last (wrap).
- UNIT, sz=0, vl=8, mask 0xC3 -> beats at elem 0 (lmask 11) and elem 6 (lmask 11, last); the two groups between are skipped, each costing one cycle.
- INDEX, base 0x8000, sc=3, vl=4, idx {1,2} then {5,0}, idx_valid delayed 3 cycles -> no ea_valid before the idx handshake; then {0x8008,0x8010}, {0x8028,0x8000} last.
- ea_ready held low 4 cycles mid-stream -> outputs stable, no beat lost. vl=0 -> done at T+1, no beats. Mode 3 -> err+done at T+1.
- rst_n low during RUN -> next edge: req_ready=1, ea_valid=0, done=0; a new request then runs normally.
